// File: rtl/regread_arbiter.sv
// Shares the two register-file read ports between the decode stage and an auxiliary requester.
// Define REGARB_STARVE_PREVENT_EN to add the starvation counter with forced aux grant.
module regread_arbiter #(
    parameter int STARVE_LIMIT = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        pipe_req,
    input  logic [4:0]  pipe_readA,
    input  logic [4:0]  pipe_readB,
    input  logic        aux_req,
    input  logic [4:0]  aux_addrA,
    input  logic [4:0]  aux_addrB,
    input  logic [31:0] rf_dataA,
    input  logic [31:0] rf_dataB,
    output logic [4:0]  ctrl_readRegA,
    output logic [4:0]  ctrl_readRegB,
    output logic        pipe_stall,
    output logic        aux_ack,
    output logic [31:0] aux_dataA,
    output logic [31:0] aux_dataB
);

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] AUX_READ = 2'd1;
    localparam logic [1:0] AUX_ACK  = 2'd2;

    if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_limit
        $error("regread_arbiter: STARVE_LIMIT must lie in 1..15");
    end

    logic [1:0]  state_q, state_d;
    logic [31:0] aux_data_a_q, aux_data_a_d;
    logic [31:0] aux_data_b_q, aux_data_b_d;
    logic        grant;

`ifdef REGARB_STARVE_PREVENT_EN
    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic [3:0] starve_cnt_q, starve_cnt_d;
    logic       starved;

    assign starved = (starve_cnt_q == LIMIT);
    assign grant   = aux_req && (!pipe_req || starved);

    // A refused request (aux_req with pipe_req) is the only way to count up.
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (state_q == IDLE) begin
            if (!aux_req || grant) begin
                starve_cnt_d = '0;
            end else begin
                starve_cnt_d = starve_cnt_q + 4'd1;
            end
        end
    end
`else
    assign grant = aux_req && !pipe_req;
`endif

    always_comb begin
        state_d      = state_q;
        aux_data_a_d = aux_data_a_q;
        aux_data_b_d = aux_data_b_q;
        case (state_q)
            IDLE: begin
                if (grant) begin
                    state_d = AUX_READ;
                end
            end
            AUX_READ: begin
                state_d      = AUX_ACK;
                aux_data_a_d = rf_dataA;
                aux_data_b_d = rf_dataB;
            end
            AUX_ACK: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            aux_data_a_q <= '0;
            aux_data_b_q <= '0;
`ifdef REGARB_STARVE_PREVENT_EN
            starve_cnt_q <= '0;
`endif
        end else begin
            state_q      <= state_d;
            aux_data_a_q <= aux_data_a_d;
            aux_data_b_q <= aux_data_b_d;
`ifdef REGARB_STARVE_PREVENT_EN
            starve_cnt_q <= starve_cnt_d;
`endif
        end
    end

    assign ctrl_readRegA = (state_q == AUX_READ) ? aux_addrA : pipe_readA;
    assign ctrl_readRegB = (state_q == AUX_READ) ? aux_addrB : pipe_readB;

    // Reset in the ack cycle aborts the transaction, so the pulse is suppressed too.
    assign aux_ack = (state_q == AUX_ACK) && !reset;

`ifdef REGARB_STARVE_PREVENT_EN
    assign pipe_stall = (state_q == AUX_READ);
`else
    assign pipe_stall = (state_q == AUX_READ) && pipe_req;
`endif

    assign aux_dataA = aux_data_a_q;
    assign aux_dataB = aux_data_b_q;

endmodule

// File: tb/tb_regread_arbiter.sv
// Scoreboard bench for regread_arbiter: aux read results queued at request time, checked at aux_ack.
module tb_regread_arbiter;

    localparam int LIMIT = 8;

    logic        clock = 1'b0;
    logic        reset;
    logic        pipe_req;
    logic [4:0]  pipe_readA, pipe_readB;
    logic        aux_req;
    logic [4:0]  aux_addrA, aux_addrB;
    logic [31:0] rf_dataA, rf_dataB;
    logic [4:0]  ctrl_readRegA, ctrl_readRegB;
    logic        pipe_stall;
    logic        aux_ack;
    logic [31:0] aux_dataA, aux_dataB;

    logic [31:0] regs [32];
    logic [63:0] exp_q [$];

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    assign rf_dataA = regs[ctrl_readRegA];
    assign rf_dataB = regs[ctrl_readRegB];

    regread_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clock        (clock),
        .reset        (reset),
        .pipe_req     (pipe_req),
        .pipe_readA   (pipe_readA),
        .pipe_readB   (pipe_readB),
        .aux_req      (aux_req),
        .aux_addrA    (aux_addrA),
        .aux_addrB    (aux_addrB),
        .rf_dataA     (rf_dataA),
        .rf_dataB     (rf_dataB),
        .ctrl_readRegA(ctrl_readRegA),
        .ctrl_readRegB(ctrl_readRegB),
        .pipe_stall   (pipe_stall),
        .aux_ack      (aux_ack),
        .aux_dataA    (aux_dataA),
        .aux_dataB    (aux_dataB)
    );

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset      = 1'b1;
        pipe_req   = 1'b0;
        aux_req    = 1'b0;
        pipe_readA = 5'd1;
        pipe_readB = 5'd2;
        aux_addrA  = 5'd0;
        aux_addrB  = 5'd0;
        cyc();
        cyc();
        reset = 1'b0;
        #1;
        checks++;
        if (pipe_stall !== 1'b0) begin
            errors++; $display("FAIL reset_stall got %b exp 0", pipe_stall);
        end
        checks++;
        if (aux_ack !== 1'b0) begin
            errors++; $display("FAIL reset_ack got %b exp 0", aux_ack);
        end
        checks++;
        if ({aux_dataA, aux_dataB} !== 64'd0) begin
            errors++; $display("FAIL reset_data got %h/%h exp 0/0", aux_dataA, aux_dataB);
        end
        checks++;
        if ({ctrl_readRegA, ctrl_readRegB} !== {5'd1, 5'd2}) begin
            errors++; $display("FAIL reset_ctrl got %0d/%0d exp 1/2", ctrl_readRegA, ctrl_readRegB);
        end
    endtask

    task automatic test_single();
        logic [4:0]  pa [3];
        logic [4:0]  pb [3];
        logic [63:0] e;
        logic        exp_stall;
        pa[0] = 5'd3;  pb[0] = 5'd7;
        pa[1] = 5'd12; pb[1] = 5'd25;
        pa[2] = 5'd31; pb[2] = 5'd1;
`ifdef REGARB_STARVE_PREVENT_EN
        exp_stall = 1'b1;
`else
        exp_stall = 1'b0;
`endif
        for (int k = 0; k < 3; k++) begin
            e          = 64'd0;
            pipe_req   = 1'b0;
            aux_req    = 1'b1;
            aux_addrA  = pa[k];
            aux_addrB  = pb[k];
            pipe_readA = 5'(k + 4);
            pipe_readB = 5'(k + 20);
            exp_q.push_back({regs[pa[k]], regs[pb[k]]});
            #1;
            checks++;
            if (ctrl_readRegA !== pipe_readA || ctrl_readRegB !== pipe_readB ||
                pipe_stall !== 1'b0 || aux_ack !== 1'b0) begin
                errors++; $display("FAIL single_idle got ctrl %0d/%0d stall %b ack %b exp %0d/%0d 0 0",
                                   ctrl_readRegA, ctrl_readRegB, pipe_stall, aux_ack, pipe_readA, pipe_readB);
            end
            cyc();
            #1;
            checks++;
            if ({ctrl_readRegA, ctrl_readRegB} !== {pa[k], pb[k]}) begin
                errors++; $display("FAIL single_read_addr got %0d/%0d exp %0d/%0d",
                                   ctrl_readRegA, ctrl_readRegB, pa[k], pb[k]);
            end
            checks++;
            if (pipe_stall !== exp_stall || aux_ack !== 1'b0) begin
                errors++; $display("FAIL single_read_stall got stall %b ack %b exp %b 0", pipe_stall, aux_ack, exp_stall);
            end
            cyc();
            aux_req = 1'b0;
            #1;
            checks++;
            if (aux_ack !== 1'b1 || pipe_stall !== 1'b0) begin
                errors++; $display("FAIL single_ack got ack %b stall %b exp 1 0", aux_ack, pipe_stall);
            end
            checks++;
            if (exp_q.size() == 0) begin
                errors++; $display("FAIL single_data got empty scoreboard exp entry");
            end else begin
                e = exp_q.pop_front();
                if ({aux_dataA, aux_dataB} !== e) begin
                    errors++; $display("FAIL single_data got %h/%h exp %h/%h", aux_dataA, aux_dataB, e[63:32], e[31:0]);
                end
            end
            cyc();
            #1;
            checks++;
            if (aux_ack !== 1'b0 || {aux_dataA, aux_dataB} !== e) begin
                errors++; $display("FAIL single_hold got ack %b data %h/%h exp 0 %h/%h",
                                   aux_ack, aux_dataA, aux_dataB, e[63:32], e[31:0]);
            end
        end
    endtask

    task automatic test_starve();
        int          idle_cycles = 0;
        int          bad = 0;
        bit          granted = 1'b0;
        logic [63:0] e;
        pipe_req   = 1'b1;
        aux_req    = 1'b1;
        aux_addrA  = 5'd9;
        aux_addrB  = 5'd10;
        pipe_readA = 5'd4;
        pipe_readB = 5'd5;
        exp_q.push_back({regs[9], regs[10]});
`ifdef REGARB_STARVE_PREVENT_EN
        for (int i = 0; i < 40 && !granted; i++) begin
            #1;
            if (pipe_stall === 1'b1) granted = 1'b1;
            else begin
                idle_cycles++;
                cyc();
            end
        end
        // LIMIT refused cycles, then the cycle whose closing edge grants
        checks++;
        if (!granted || idle_cycles != LIMIT + 1) begin
            errors++; $display("FAIL starve_grant_cycle got granted %b after %0d exp after %0d", granted, idle_cycles, LIMIT + 1);
        end
        checks++;
        if ({ctrl_readRegA, ctrl_readRegB} !== {5'd9, 5'd10}) begin
            errors++; $display("FAIL starve_read_addr got %0d/%0d exp 9/10", ctrl_readRegA, ctrl_readRegB);
        end
        bad = idle_cycles;
`else
        for (int i = 0; i < 20; i++) begin
            #1;
            if (pipe_stall !== 1'b0 || aux_ack !== 1'b0 || ctrl_readRegA !== 5'd4) bad++;
            cyc();
        end
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL strict_no_grant got %0d bad cycles exp 0", bad);
        end
        pipe_req = 1'b0;
        #1;
        cyc();
        #1;
        checks++;
        if ({ctrl_readRegA, ctrl_readRegB} !== {5'd9, 5'd10} || pipe_stall !== 1'b0) begin
            errors++; $display("FAIL strict_grant got %0d/%0d stall %b exp 9/10 0", ctrl_readRegA, ctrl_readRegB, pipe_stall);
        end
`endif
        cyc();
        aux_req = 1'b0;
        #1;
        checks++;
        if (aux_ack !== 1'b1 || pipe_stall !== 1'b0) begin
            errors++; $display("FAIL starve_ack got ack %b stall %b exp 1 0", aux_ack, pipe_stall);
        end
        checks++;
        if (exp_q.size() == 0) begin
            errors++; $display("FAIL starve_data got empty scoreboard exp entry");
        end else begin
            e = exp_q.pop_front();
            if ({aux_dataA, aux_dataB} !== e) begin
                errors++; $display("FAIL starve_data got %h/%h exp %h/%h", aux_dataA, aux_dataB, e[63:32], e[31:0]);
            end
        end
        cyc();
    endtask

    task automatic test_restart();
        int          bad = 0;
        int          idle_cycles = 0;
        bit          granted = 1'b0;
        logic [63:0] e;
        pipe_req   = 1'b1;
        aux_req    = 1'b1;
        aux_addrA  = 5'd14;
        aux_addrB  = 5'd15;
        pipe_readA = 5'd4;
        pipe_readB = 5'd5;
        for (int i = 0; i < 3; i++) begin
            #1;
            if (pipe_stall !== 1'b0 || aux_ack !== 1'b0) bad++;
            cyc();
        end
        aux_req = 1'b0;
        #1;
        if (pipe_stall !== 1'b0 || aux_ack !== 1'b0) bad++;
        cyc();
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL restart_blocked got %0d bad cycles exp 0", bad);
        end
`ifdef REGARB_STARVE_PREVENT_EN
        aux_req = 1'b1;
        exp_q.push_back({regs[14], regs[15]});
        for (int i = 0; i < 40 && !granted; i++) begin
            #1;
            if (pipe_stall === 1'b1) granted = 1'b1;
            else begin
                idle_cycles++;
                cyc();
            end
        end
        checks++;
        if (!granted || idle_cycles != LIMIT + 1) begin
            errors++; $display("FAIL restart_grant_cycle got granted %b after %0d exp after %0d", granted, idle_cycles, LIMIT + 1);
        end
        cyc();
        aux_req = 1'b0;
        #1;
        checks++;
        if (aux_ack !== 1'b1 || exp_q.size() == 0) begin
            errors++; $display("FAIL restart_ack got ack %b queued %0d exp 1 1", aux_ack, exp_q.size());
        end else begin
            e = exp_q.pop_front();
            if ({aux_dataA, aux_dataB} !== e) begin
                errors++; $display("FAIL restart_data got %h/%h exp %h/%h", aux_dataA, aux_dataB, e[63:32], e[31:0]);
            end
        end
        cyc();
`else
        for (int i = 0; i < 10; i++) begin
            #1;
            if (aux_ack !== 1'b0 || pipe_stall !== 1'b0) bad++;
            cyc();
        end
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL abandon_no_ack got %0d bad cycles exp 0", bad);
        end
`endif
    endtask

    task automatic test_reset_abort();
        int bad = 0;
        pipe_req   = 1'b0;
        aux_req    = 1'b1;
        aux_addrA  = 5'd3;
        aux_addrB  = 5'd7;
        pipe_readA = 5'd1;
        pipe_readB = 5'd2;
        #1;
        cyc();
        #1;
        checks++;
        if ({ctrl_readRegA, ctrl_readRegB} !== {5'd3, 5'd7}) begin
            errors++; $display("FAIL abort_read_addr got %0d/%0d exp 3/7", ctrl_readRegA, ctrl_readRegB);
        end
        reset = 1'b1;
        #1;
        cyc();
        reset   = 1'b0;
        aux_req = 1'b0;
        #1;
        checks++;
        if ({aux_dataA, aux_dataB} !== 64'd0 || aux_ack !== 1'b0) begin
            errors++; $display("FAIL abort_read_data got %h/%h ack %b exp 0/0 0", aux_dataA, aux_dataB, aux_ack);
        end
        checks++;
        if ({ctrl_readRegA, ctrl_readRegB} !== {5'd1, 5'd2} || pipe_stall !== 1'b0) begin
            errors++; $display("FAIL abort_read_idle got %0d/%0d stall %b exp 1/2 0", ctrl_readRegA, ctrl_readRegB, pipe_stall);
        end
        for (int i = 0; i < 4; i++) begin
            cyc();
            #1;
            if (aux_ack !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL abort_read_no_ack got %0d ack cycles exp 0", bad);
        end
        aux_req = 1'b1;
        #1;
        cyc();
        #1;
        cyc();
        aux_req = 1'b0;
        reset   = 1'b1;
        #1;
        checks++;
        if (aux_ack !== 1'b0) begin
            errors++; $display("FAIL abort_ack_gate got %b exp 0", aux_ack);
        end
        cyc();
        reset = 1'b0;
        #1;
        checks++;
        if ({aux_dataA, aux_dataB} !== 64'd0 || aux_ack !== 1'b0) begin
            errors++; $display("FAIL abort_ack_data got %h/%h ack %b exp 0/0 0", aux_dataA, aux_dataB, aux_ack);
        end
    endtask

    task automatic test_back_to_back();
        int          ack_idx [$];
        int          first;
        int          second;
        logic [63:0] e;
        pipe_req   = 1'b0;
        aux_req    = 1'b1;
        aux_addrA  = 5'd12;
        aux_addrB  = 5'd25;
        pipe_readA = 5'd6;
        pipe_readB = 5'd8;
        exp_q.push_back({regs[12], regs[25]});
        exp_q.push_back({regs[12], regs[25]});
        for (int i = 0; i < 6; i++) begin
            if (i == 5) aux_req = 1'b0;
            #1;
            if (aux_ack === 1'b1) begin
                ack_idx.push_back(i);
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL b2b_data got unexpected ack at cycle %0d exp none", i);
                end else begin
                    e = exp_q.pop_front();
                    if ({aux_dataA, aux_dataB} !== e) begin
                        errors++; $display("FAIL b2b_data got %h/%h exp %h/%h", aux_dataA, aux_dataB, e[63:32], e[31:0]);
                    end
                end
            end
            cyc();
        end
        first  = (ack_idx.size() > 0) ? ack_idx[0] : -1;
        second = (ack_idx.size() > 1) ? ack_idx[1] : -1;
        checks++;
        if (ack_idx.size() != 2 || first != 2 || second != 5) begin
            errors++; $display("FAIL b2b_ack_timing got %0d acks at %0d,%0d exp 2 acks at 2,5", ack_idx.size(), first, second);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++; $display("FAIL scoreboard_drain got %0d left exp 0", exp_q.size());
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) regs[i] = 32'hC0DE_0000 + 32'(i * 37);
        regs[3] = 32'h0000_1234;
        regs[7] = 32'h0000_BEEF;
        test_reset();
        test_single();
        test_starve();
        test_restart();
        test_reset_abort();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1, "watchdog");
    end

endmodule
